// File: rtl/sl_tx_fifo_channel.sv
// SL two-wire serial transmitter fed from a word FIFO; each word is framed as
// data bits, optional parity, a both-low stop phase and optional idle gap phases.
module sl_tx_fifo_channel #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 8,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1,
    localparam int BITS_W    = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              enable,
    input  logic              flush,
    input  logic [BITS_W-1:0] cfg_bits,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [1:0]        cfg_parity,
    input  logic [7:0]        cfg_gap,
    output logic              SL0,
    output logic              SL1,
    output logic              busy,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              fifo_empty,
    output logic              word_done,
    output logic              cfg_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_BIT,
        ST_BIT_END,
        ST_PARITY,
        ST_PAR_END,
        ST_STOP,
        ST_STOP_END,
        ST_GAP
    } state_t;

    // ---------------- FIFO ----------------
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [DATA_W-1:0] rd_data_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [LVL_W-1:0]  level_reg;
    logic              fifo_full;
    logic              push;
    logic              pop;

    state_t            state_reg;

    assign fifo_full  = (level_reg == LVL_W'(FIFO_DEPTH));
    assign fifo_empty = (level_reg == '0);
    assign fifo_level = level_reg;
    assign s_ready    = !fifo_full;
    assign push       = s_valid && s_ready;
    // Head may have been flushed between the IDLE decision and LOAD.
    assign pop        = (state_reg == ST_LOAD) && !fifo_empty;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_reg] <= s_data;
        end
        rd_data_reg <= mem[rd_ptr_reg];
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    // ---------------- Framing FSM ----------------
    logic [DIV_W-1:0]  div_cnt_reg;
    logic [BITS_W-1:0] bit_cnt_reg;
    logic [7:0]        gap_cnt_reg;
    logic [DATA_W-1:0] shift_reg;
    logic              par_acc_reg;
    logic [BITS_W-1:0] bits_reg;
    logic [DIV_W-1:0]  div_reg;
    logic [1:0]        par_mode_reg;
    logic [7:0]        gap_reg;
    logic              sl0_reg;
    logic              sl1_reg;
    logic              cfg_err_reg;

    logic              phase_end;
    logic              last_bit;
    logic              gap_last;
    logic              par_bit;
    logic              cfg_bad;
    logic [DATA_W-1:0] shift_next;

    assign phase_end  = (div_cnt_reg == div_reg);
    assign last_bit   = (bit_cnt_reg == bits_reg - BITS_W'(1));
    assign gap_last   = (gap_cnt_reg == gap_reg - 8'd1);
    // Even mode sends the running XOR; odd and reserved modes send its inverse.
    assign par_bit    = (par_mode_reg == 2'd2) ? par_acc_reg : ~par_acc_reg;
    assign cfg_bad    = (cfg_bits == '0) || (cfg_bits > BITS_W'(DATA_W));
    assign shift_next = shift_reg >> 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            div_cnt_reg  <= '0;
            bit_cnt_reg  <= '0;
            gap_cnt_reg  <= '0;
            shift_reg    <= '0;
            par_acc_reg  <= 1'b0;
            bits_reg     <= '0;
            div_reg      <= '0;
            par_mode_reg <= '0;
            gap_reg      <= '0;
            sl0_reg      <= 1'b1;
            sl1_reg      <= 1'b1;
            cfg_err_reg  <= 1'b0;
        end else begin
            cfg_err_reg <= 1'b0;
            if (state_reg == ST_IDLE || state_reg == ST_LOAD || phase_end) begin
                div_cnt_reg <= '0;
            end else begin
                div_cnt_reg <= div_cnt_reg + 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    sl0_reg <= 1'b1;
                    sl1_reg <= 1'b1;
                    if (enable && !fifo_empty) begin
                        state_reg <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    bits_reg     <= cfg_bits;
                    div_reg      <= cfg_div;
                    par_mode_reg <= cfg_parity;
                    gap_reg      <= cfg_gap;
                    bit_cnt_reg  <= '0;
                    gap_cnt_reg  <= '0;
                    par_acc_reg  <= 1'b0;
                    shift_reg    <= rd_data_reg;
                    if (cfg_bad) begin
                        cfg_err_reg <= 1'b1;
                        state_reg   <= ST_IDLE;
                    end else begin
                        state_reg <= ST_BIT;
                        sl0_reg   <= rd_data_reg[0];
                        sl1_reg   <= ~rd_data_reg[0];
                    end
                end
                ST_BIT: begin
                    if (phase_end) begin
                        par_acc_reg <= par_acc_reg ^ shift_reg[0];
                        state_reg   <= ST_BIT_END;
                        sl0_reg     <= 1'b1;
                        sl1_reg     <= 1'b1;
                    end
                end
                ST_BIT_END: begin
                    if (phase_end) begin
                        if (!last_bit) begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            shift_reg   <= shift_next;
                            state_reg   <= ST_BIT;
                            sl0_reg     <= shift_next[0];
                            sl1_reg     <= ~shift_next[0];
                        end else if (par_mode_reg == 2'd0) begin
                            state_reg <= ST_STOP;
                            sl0_reg   <= 1'b0;
                            sl1_reg   <= 1'b0;
                        end else begin
                            state_reg <= ST_PARITY;
                            sl0_reg   <= par_bit;
                            sl1_reg   <= ~par_bit;
                        end
                    end
                end
                ST_PARITY: begin
                    if (phase_end) begin
                        state_reg <= ST_PAR_END;
                        sl0_reg   <= 1'b1;
                        sl1_reg   <= 1'b1;
                    end
                end
                ST_PAR_END: begin
                    if (phase_end) begin
                        state_reg <= ST_STOP;
                        sl0_reg   <= 1'b0;
                        sl1_reg   <= 1'b0;
                    end
                end
                ST_STOP: begin
                    if (phase_end) begin
                        state_reg <= ST_STOP_END;
                        sl0_reg   <= 1'b1;
                        sl1_reg   <= 1'b1;
                    end
                end
                ST_STOP_END: begin
                    if (phase_end) begin
                        state_reg <= (gap_reg != 8'd0) ? ST_GAP : ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (phase_end) begin
                        if (gap_last) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            gap_cnt_reg <= gap_cnt_reg + 8'd1;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    sl0_reg   <= 1'b1;
                    sl1_reg   <= 1'b1;
                end
            endcase
        end
    end

    assign SL0       = sl0_reg;
    assign SL1       = sl1_reg;
    assign cfg_err   = cfg_err_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign word_done = phase_end &&
                       (((state_reg == ST_STOP_END) && (gap_reg == 8'd0)) ||
                        ((state_reg == ST_GAP) && gap_last));

endmodule
